ras_mc_stack: RTL

//  Multi-channel return-address stack (RAS) for the CPU front-end. Holds NCH independent LIFO call stacks.
//  One channel is served per cycle, chosen by i_ch_sel (one channel per HW thread).

---
 rtl/ras_pkg.sv | 29 ++
 rtl/ras_ch_ctrl.sv | 127 ++++++++++++
 rtl/ras_mc_stack.sv | 81 ++++++++
 3 files changed

// File: rtl/ras_pkg.sv
// Shared types for the multi-channel return-address stack: the per-cycle
// stack operation and the helper that decodes push/pop requests into it.
package ras_pkg;

    typedef enum logic [1:0] {
        RAS_IDLE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL
    } ras_op_e;

    // A pop on an empty stack decays to IDLE. A push+pop on an empty stack
    // is a plain push. A push+pop on a non-empty stack replaces the top entry.
    function automatic ras_op_e ras_decode(input logic push,
                                           input logic pop,
                                           input logic empty);
        ras_op_e op;
        op = RAS_IDLE;
        if (push && pop && !empty) begin
            op = RAS_REPL;
        end else if (push) begin
            op = RAS_PUSH;
        end else if (pop && !empty) begin
            op = RAS_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_ch_ctrl.sv
// Per-channel RAS controller. It holds the top pointer, the occupancy count,
// one speculative checkpoint, and the optional sticky error flags.
// Optional feature: `define RAS_ERR_FLAGS_EN builds the ovf/udf flags.
module ras_ch_ctrl #(
    parameter  int DPT  = 8,
    localparam int PTRW = $clog2(DPT)
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            sel_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            ckpt_i,
    input  logic            restore_i,
    input  logic            flush_i,
    output logic            wr_en_o,
    output logic [PTRW-1:0] wr_ptr_o,
    output logic [PTRW-1:0] rd_ptr_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            ckpt_valid_o,
    output logic            ovf_o,
    output logic            udf_o
);
    import ras_pkg::*;

    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);
    localparam logic [PTRW:0]   CNT_ONE = (PTRW + 1)'(1);

    logic [PTRW-1:0] top_q, top_d, ck_top_q, ck_top_d;
    logic [PTRW:0]   cnt_q, cnt_d, ck_cnt_q, ck_cnt_d;
    logic            ckv_q, ckv_d;
    ras_op_e         op;
    logic            act;

    assign full_o       = cnt_q[PTRW];
    assign empty_o      = (cnt_q == '0);
    assign ckpt_valid_o = ckv_q;
    assign op           = ras_decode(push_i, pop_i, empty_o);
    // A flush or a restore on this channel drops every other operation in the same cycle.
    assign act          = sel_i && !flush_i && !restore_i;
    assign wr_en_o      = act && (op == RAS_PUSH || op == RAS_REPL);
    assign wr_ptr_o     = (op == RAS_REPL) ? top_q - PTR_ONE : top_q;
    assign rd_ptr_o     = top_q - PTR_ONE;

    // Next-state logic for the pointers and the checkpoint, in order flush > restore > push/pop+ckpt.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the block infers a latch.
        top_d    = top_q;
        cnt_d    = cnt_q;
        ck_top_d = ck_top_q;
        ck_cnt_d = ck_cnt_q;
        ckv_d    = ckv_q;
        if (flush_i) begin
            top_d = '0;
            cnt_d = '0;
            ckv_d = 1'b0;
        end else if (sel_i && restore_i) begin
            if (ckv_q) begin
                top_d = ck_top_q;
                cnt_d = ck_cnt_q;
                ckv_d = 1'b0;
            end
        end else if (sel_i) begin
            if (ckpt_i) begin
                ck_top_d = top_q;
                ck_cnt_d = cnt_q;
                ckv_d    = 1'b1;
            end
            case (op)
                RAS_PUSH: begin
                    // The pointer wraps on a full stack, so the oldest entry is overwritten.
                    top_d = top_q + PTR_ONE;
                    if (!full_o) cnt_d = cnt_q + CNT_ONE;
                end
                RAS_POP: begin
                    top_d = top_q - PTR_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Pointer, count and checkpoint registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            // NOTE: the state registers use non-blocking assignments, so every register samples pre-edge values.
            top_q    <= '0;
            cnt_q    <= '0;
            ck_top_q <= '0;
            ck_cnt_q <= '0;
            ckv_q    <= 1'b0;
        end else begin
            top_q    <= top_d;
            cnt_q    <= cnt_d;
            ck_top_q <= ck_top_d;
            ck_cnt_q <= ck_cnt_d;
            ckv_q    <= ckv_d;
        end
    end

`ifdef RAS_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    // Sticky overflow and underflow flags. Only operations that actually execute can set them.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (act) begin
            if (op == RAS_PUSH && full_o)       ovf_q <= 1'b1;
            if (pop_i && !push_i && empty_o)    udf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

// File: rtl/ras_mc_stack.sv
// Multi-channel return-address stack: NCH independent wrapping LIFOs with
// per-channel checkpoint/restore and a global flush.
// Optional feature: `define RAS_ERR_FLAGS_EN enables sticky o_ovf/o_udf flags.
module ras_mc_stack #(
    parameter  int NCH  = 2,
    parameter  int DPT  = 8,
    parameter  int DW   = 32,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int PTRW = $clog2(DPT)
) (
    input  logic           clk,
    input  logic           areset,
    input  logic [CHW-1:0] i_ch_sel,
    input  logic           i_push_en,
    input  logic [DW-1:0]  i_push_data,
    input  logic           i_pop_en,
    output logic [DW-1:0]  o_pop_data,
    output logic           o_full,
    output logic           o_empty,
    input  logic           i_ckpt_en,
    input  logic           i_restore_en,
    output logic [NCH-1:0] o_ckpt_valid,
    input  logic           i_flush,
    output logic [NCH-1:0] o_ovf,
    output logic [NCH-1:0] o_udf
);
    localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);

    // Flat storage. Entry {ch, ptr} belongs to channel ch.
    logic [DW-1:0] mem [NCH*DPT];

    logic                      ch_ok;
    logic [NCH-1:0]            sel, wr_en, full, empty;
    logic [NCH-1:0][PTRW-1:0]  wr_ptr, rd_ptr;

    assign ch_ok = ({1'b0, i_ch_sel} < NCH_W);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign sel[g] = ch_ok && (i_ch_sel == CHW'(g));

        ras_ch_ctrl #(.DPT(DPT)) u_ctrl (
            .clk          (clk),
            .areset       (areset),
            .sel_i        (sel[g]),
            .push_i       (i_push_en),
            .pop_i        (i_pop_en),
            .ckpt_i       (i_ckpt_en),
            .restore_i    (i_restore_en),
            .flush_i      (i_flush),
            .wr_en_o      (wr_en[g]),
            .wr_ptr_o     (wr_ptr[g]),
            .rd_ptr_o     (rd_ptr[g]),
            .full_o       (full[g]),
            .empty_o      (empty[g]),
            .ckpt_valid_o (o_ckpt_valid[g]),
            .ovf_o        (o_ovf[g]),
            .udf_o        (o_udf[g])
        );
    end

    // Storage write from the selected channel's controller.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. The counts alone decide which entries are meaningful.
        if (ch_ok && wr_en[i_ch_sel]) begin
            mem[{i_ch_sel, wr_ptr[i_ch_sel]}] <= i_push_data;
        end
    end

    // Output mux on the selected channel. An out-of-range channel reads as empty.
    always_comb begin
        o_pop_data = '0;
        o_full     = 1'b0;
        o_empty    = 1'b1;
        if (ch_ok) begin
            o_pop_data = mem[{i_ch_sel, rd_ptr[i_ch_sel]}];
            o_full     = full[i_ch_sel];
            o_empty    = empty[i_ch_sel];
        end
    end

endmodule
